uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter with an input FIFO, replacing the fixed-format 8N1 transmitter in the TP2 serial path. Accepts bytes over a valid/ready handshake, buffers them, and serialises frames LSB-first. Frame format is set per frame: 5–8 data bits, optional even/odd parity, 1 or 2 stop bits. Driven by the shared baud-rate generator tick (OVERSAMPLE ticks per bit); consecutive frames go out back-to-back without idle gaps.

Parameters:
DATA_BITS_MAX, 8, width of s_data and the maximum data bits per frame (5..8)
OVERSAMPLE, 16, ticks per bit period (≥2)
FIFO_DEPTH, 4, input FIFO entries (power of two, ≥2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
tick  in  1  baud enable pulse, one clk wide
s_data  in  DATA_BITS_MAX  byte to transmit
s_valid  in  1  s_data valid
s_ready  out  1  FIFO can accept (= !fifo_full)
data_len  in  4  data bits per frame; <5 treated as 5, >DATA_BITS_MAX treated as DATA_BITS_MAX
parity_en  in  1  1 = parity bit present
parity_odd  in  1  0 = even, 1 = odd parity
two_stop  in  1  1 = two stop bits
tx  out  1  serial line, registered, idle high
tx_done  out  1  one-cycle pulse at end of each frame
busy  out  1  high while a frame is on the line (state != IDLE)
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently buffered

Behaviour:
- Reset (clk edge with reset=1): tx=1, tx_done=0, busy=0, fifo_count=0, s_ready=1, state IDLE, FIFO flushed, counters cleared. Reset mid-frame aborts the frame; tx is high on the next cycle and no tx_done is issued.
- Push: s_valid && s_ready writes s_data on that edge. When full, s_ready=0 and the word is not taken, even if the FSM pops in the same cycle. Push and pop in the same cycle leave fifo_count unchanged. No fall-through: a word pushed into an empty FIFO is popped on the following cycle at the earliest.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If the FIFO is non-empty, pop the head into the shift register, latch data_len (clamped), parity_en, parity_odd and two_stop, clear the tick and bit counters, and go to START. Config inputs are sampled only at pop; changes mid-frame affect only later frames.
- Bit timing: in each of START/DATA/PARITY/STOP the tick counter increments on every tick. The bit period ends on the tick where the counter = OVERSAMPLE-1; the counter then wraps to 0. Cycles with tick=0 hold all state.
- START: tx=0 from the cycle after the pop; go to DATA at end of period.
- DATA: tx = shift_reg[0]; at each period end shift right, bit counter +1. After the data_len-th bit go to PARITY if parity_en, otherwise go to STOP.
- PARITY: tx = XOR of the data_len latched bits, inverted if parity_odd. Go to STOP at end of period. Bits above data_len never affect tx or parity.
- STOP: tx=1 for 1 or 2 bit periods. At the end of the last stop period, pulse tx_done for one cycle. If the FIFO is non-empty in that cycle, pop and go directly to START (back-to-back, no extra idle bit). Otherwise go to IDLE.
- Frame length in ticks = OVERSAMPLE × (1 + data_len + parity_en + 1 + two_stop).
- Illegal state encodings recover to IDLE with tx=1.
- busy=1 from the cycle after a pop until the cycle after the tx_done pulse; it stays 1 across back-to-back frames.

Test Plan:
- Reset, tick every cycle, 8N1, push 0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), each level 16 cycles; one tx_done 160 ticks after the start edge; busy falls afterward.
- 7E1, push 0x41 -> 7 data bits 1,0,0,0,0,0,1; parity bit 0; frame 160 ticks. Same test with parity_odd=1 -> parity bit 1.
- 8O2, push 0x07 -> parity bit 0; two stop bits; frame 192 ticks. data_len=3 -> frame behaves as 5 data bits.
- tick held 0, push 6 words on consecutive cycles with FIFO_DEPTH=4 -> first word popped one cycle after push; 5 words accepted; s_ready=0 on the 6th until the first frame ends; words appear on tx in order with no idle bits between frames; 5 tx_done pulses.
- Toggle parity_en and two_stop mid-frame -> current frame unchanged; next frame uses the new values.
- Assert reset during the DATA state with 2 words buffered -> tx=1 next cycle, fifo_count=0, no tx_done, no further frames.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// UART transmitter with a small input FIFO and a per-frame format.
// Format options: 5..DATA_BITS_MAX data bits, optional even/odd parity, and 1 or 2 stop bits.
module uart_tx_cfg #(
  parameter int DATA_BITS_MAX = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tick,
  input  logic [DATA_BITS_MAX-1:0]         s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [3:0]                       data_len,
  input  logic                             parity_en,
  input  logic                             parity_odd,
  input  logic                             two_stop,
  output logic                             tx,
  output logic                             tx_done,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LEN_MAX   = 4'(DATA_BITS_MAX);
  localparam logic [3:0]    LEN_MIN   = 4'd5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS_MAX-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr_reg;
  logic [AW-1:0]            rd_ptr_reg;
  logic [CW-1:0]            count_reg;

  // Frame engine state
  state_t                   state_reg;
  logic [TW-1:0]            tick_cnt_reg;
  logic [3:0]               bit_cnt_reg;
  logic [DATA_BITS_MAX-1:0] shift_reg;
  logic [3:0]               len_reg;
  logic                     par_en_reg;
  logic                     par_odd_reg;
  logic                     two_stop_reg;
  logic                     par_acc_reg;
  logic                     tx_reg;
  logic                     tx_done_reg;
  logic                     busy_reg;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  logic                     period_end;
  logic                     last_stop;
  logic [3:0]               len_clamped;

  always_comb begin
    fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    fifo_empty = (count_reg == '0);
    push       = s_valid && !fifo_full;
    period_end = tick && (tick_cnt_reg == TICK_LAST);
    // The final stop period is the only one when two_stop is clear, else the second one.
    last_stop  = (state_reg == STOP) && period_end && (!two_stop_reg || (bit_cnt_reg != 4'd0));
    pop        = !fifo_empty && ((state_reg == IDLE) || last_stop);
    if (data_len < LEN_MIN) begin
      len_clamped = LEN_MIN;
    end else if (data_len > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end else begin
      len_clamped = data_len;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      len_reg      <= LEN_MIN;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
      par_acc_reg  <= 1'b0;
      tx_reg       <= 1'b1;
      tx_done_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      tx_done_reg <= 1'b0;

      if ((state_reg != IDLE) && tick) begin
        tick_cnt_reg <= period_end ? '0 : tick_cnt_reg + TW'(1);
      end

      case (state_reg)
        IDLE: begin
          tx_reg   <= 1'b1;
          busy_reg <= 1'b0;
        end
        START: begin
          if (period_end) begin
            state_reg <= DATA;
            tx_reg    <= shift_reg[0];
          end
        end
        DATA: begin
          if (period_end) begin
            shift_reg   <= shift_reg >> 1;
            par_acc_reg <= par_acc_reg ^ shift_reg[0];
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == len_reg - 4'd1) begin
              bit_cnt_reg <= 4'd0;
              if (par_en_reg) begin
                state_reg <= PARITY;
                tx_reg    <= par_acc_reg ^ shift_reg[0] ^ par_odd_reg;
              end else begin
                state_reg <= STOP;
                tx_reg    <= 1'b1;
              end
            end else begin
              tx_reg <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (period_end) begin
            state_reg   <= STOP;
            tx_reg      <= 1'b1;
            bit_cnt_reg <= 4'd0;
          end
        end
        STOP: begin
          tx_reg <= 1'b1;
          if (period_end) begin
            if (two_stop_reg && (bit_cnt_reg == 4'd0)) begin
              bit_cnt_reg <= 4'd1;
            end else begin
              state_reg   <= IDLE;
              bit_cnt_reg <= 4'd0;
              tx_done_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg    <= IDLE;
          tx_reg       <= 1'b1;
          busy_reg     <= 1'b0;
          tick_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
        end
      endcase

      // A pop overrides the state update above, so the last stop bit flows straight into START.
      if (pop) begin
        shift_reg    <= mem[rd_ptr_reg];
        len_reg      <= len_clamped;
        par_en_reg   <= parity_en;
        par_odd_reg  <= parity_odd;
        two_stop_reg <= two_stop;
        par_acc_reg  <= 1'b0;
        tick_cnt_reg <= '0;
        bit_cnt_reg  <= 4'd0;
        state_reg    <= START;
        tx_reg       <= 1'b0;
        busy_reg     <= 1'b1;
      end
    end
  end

  assign s_ready    = !fifo_full;
  assign tx         = tx_reg;
  assign tx_done    = tx_done_reg;
  assign busy       = busy_reg;
  assign fifo_count = count_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed frames with hand-computed bit sequences.
// A tick-counting monitor checks each frame on tx against a queue of expected frames.
module tb_uart_tx_cfg;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       tick_on;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] data_len;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic       tx;
  logic       tx_done;
  logic       busy;
  logic [2:0] fifo_count;

  assign tick = tick_on;

  always #5 clk = ~clk;

  uart_tx_cfg #(.DATA_BITS_MAX(8), .OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .data_len(data_len), .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .tx(tx), .tx_done(tx_done), .busy(busy), .fifo_count(fifo_count)
  );

  // Expected frame: bits[i] is the i-th level on the line (start first).
  typedef struct {
    logic [15:0] bits;
    int          nbits;
  } frame_t;

  frame_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int frames_done = 0;
  int done_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic        m_tick, m_rst, prev_tx, active, ferr;
  frame_t      cur;
  logic [15:0] obs;
  int          tcnt, bidx;

  task start_frame();
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got start bit expected idle line");
      active = 1'b0;
    end else begin
      cur    = exp_q.pop_front();
      active = 1'b1;
      tcnt   = 0;
      bidx   = 0;
      ferr   = 1'b0;
      obs    = '0;
    end
  endtask

  initial begin
    prev_tx = 1'b1;
    active  = 1'b0;
  end

  always @(posedge clk) begin
    m_tick = tick;
    m_rst  = reset;
    #1;
    if (tx_done) done_total++;
    if (m_rst) begin
      active  = 1'b0;
    end else if (active) begin
      if (m_tick) begin
        tcnt++;
        if (tcnt == OS) begin
          tcnt = 0;
          bidx++;
        end
      end
      if (bidx == cur.nbits) begin
        checks++;
        if (ferr || !tx_done) begin
          errors++;
          $display("FAIL frame: got bits %0h tx_done %0b expected bits %0h tx_done 1",
                   obs, tx_done, cur.bits);
        end else begin
          $display("frame ok: bits %0h (%0d bits)", obs, cur.nbits);
        end
        frames_done++;
        active = 1'b0;
        if (tx == 1'b0) start_frame();
      end else begin
        if (tcnt == OS / 2) obs[bidx] = tx;
        if (tx !== cur.bits[bidx]) ferr = 1'b1;
        if (tx_done) ferr = 1'b1;
      end
    end else if (prev_tx && !tx) begin
      start_frame();
    end
    prev_tx = tx;
  end

  // ---------------- stimulus ----------------
  task automatic set_cfg(input logic [3:0] len, input logic pe, input logic po, input logic ts);
    @(negedge clk);
    data_len   = len;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
  endtask

  task automatic expect_frame(input logic [15:0] bits, input int nbits);
    frame_t f;
    f.bits  = bits;
    f.nbits = nbits;
    exp_q.push_back(f);
  endtask

  task automatic send(input logic [7:0] d);
    int k = 0;
    @(negedge clk);
    s_data  = d;
    s_valid = 1'b1;
    while (!s_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!s_ready) check("send_timeout", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int target = frames_done + n;
    int k = 0;
    while (frames_done < target && k < 5000) begin
      @(posedge clk);
      k++;
    end
    #2;
    check("frame_wait", {31'd0, frames_done >= target}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [3:0]  len;
    logic        pe, po, ts;
    logic [15:0] bits;
    int          nbits;
  } vec_t;

  vec_t vecs[6];
  logic [7:0]  burst_w[5];
  logic [15:0] burst_f[5];
  int cyc, dn, zero_cycles;

  initial begin
    // 8N1 0x55, 7E1 0x41, 7O1 0x41, 8O2 0x07, len 3 (->5) even 0xE6, len 15 (->8) 0x80
    vecs[0] = '{8'h55, 4'd8,  1'b0, 1'b0, 1'b0, 16'h02AA, 10};
    vecs[1] = '{8'h41, 4'd7,  1'b1, 1'b0, 1'b0, 16'h0282, 10};
    vecs[2] = '{8'h41, 4'd7,  1'b1, 1'b1, 1'b0, 16'h0382, 10};
    vecs[3] = '{8'h07, 4'd8,  1'b1, 1'b1, 1'b1, 16'h0C0E, 12};
    vecs[4] = '{8'hE6, 4'd3,  1'b1, 1'b0, 1'b0, 16'h008C, 8};
    vecs[5] = '{8'h80, 4'd15, 1'b0, 1'b0, 1'b0, 16'h0300, 10};
    burst_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    burst_f = '{16'h0222, 16'h0244, 16'h0266, 16'h0288, 16'h02AA};

    reset = 1'b1; tick_on = 1'b0; s_valid = 1'b0; s_data = '0;
    data_len = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    check("rst_s_ready", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    reset   = 1'b0;
    tick_on = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_cfg(vecs[i].len, vecs[i].pe, vecs[i].po, vecs[i].ts);
      expect_frame(vecs[i].bits, vecs[i].nbits);
      send(vecs[i].data);
      @(posedge clk);
      #1;
      check("busy_in_frame", {31'd0, busy}, 32'd1);
      wait_frames(1);
      repeat (3) @(posedge clk);
      #1;
      check("busy_after_frame", {31'd0, busy}, 32'd0);
    end

    // FIFO fill with ticks stopped, then release ticks and time five back-to-back frames.
    @(negedge clk);
    tick_on = 1'b0;
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) expect_frame(burst_f[i], 10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_data  = burst_w[i];
      s_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) begin
        check("no_fallthrough_busy", {31'd0, busy}, 32'd0);
        check("first_push_count", {29'd0, fifo_count}, 32'd1);
      end
      if (i == 1) begin
        check("pop_busy", {31'd0, busy}, 32'd1);
        check("pop_tx_start", {31'd0, tx}, 32'd0);
        check("push_pop_count", {29'd0, fifo_count}, 32'd1);
      end
    end
    check("full_count", {29'd0, fifo_count}, 32'd4);
    @(negedge clk);
    s_data = 8'h66;
    #1;
    check("full_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("full_no_take", {29'd0, fifo_count}, 32'd4);
    s_valid = 1'b0;
    @(negedge clk);
    tick_on = 1'b1;
    cyc = 0;
    dn  = 0;
    while (dn < 5 && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (tx_done) dn++;
      if (cyc == 159) check("s_ready_before_end", {31'd0, s_ready}, 32'd0);
      if (cyc == 160) begin
        check("s_ready_after_end", {31'd0, s_ready}, 32'd1);
        check("count_after_end", {29'd0, fifo_count}, 32'd3);
      end
    end
    check("burst_cycles", cyc, 32'd800);
    repeat (5) @(posedge clk);

    // Config change mid-frame: first frame stays 8N1, second picks up 8E2.
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    expect_frame(16'h034A, 10);
    expect_frame(16'h0C78, 12);
    send(8'hA5);
    send(8'h3C);
    repeat (30) @(posedge clk);
    set_cfg(4'd8, 1'b1, 1'b0, 1'b1);
    wait_frames(2);
    repeat (5) @(posedge clk);

    // Reset during DATA with two words buffered.
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
    expect_frame(16'h021E, 10);
    send(8'h0F);
    send(8'hF0);
    send(8'h33);
    repeat (40) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_count", {29'd0, fifo_count}, 32'd0);
    check("midrst_tx_done", {31'd0, tx_done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    zero_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (tx_done) dn++;
      if (!tx) zero_cycles++;
    end
    check("post_rst_tx_done", dn, 32'd0);
    check("post_rst_tx_low", zero_cycles, 32'd0);

    check("queue_empty", exp_q.size(), 32'd0);
    check("frames_total", frames_done, 32'd13);
    check("tx_done_total", done_total, 32'd13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
